if_prefetch: RTL and testbench

Instruction-fetch front end that sits directly upstream of the IF/ID pipeline registers. It replaces the single-cycle fetch path with a variable-latency instruction-memory handshake and a small prefetch queue. It supplies `{pc+1, instr}` pairs to IF/ID, honours pipeline stalls, flushes on a taken branch or jump redirect from the MEM stage, and stops fetching on halt.

---
 rtl/if_prefetch.sv | 154 +++++++++++++++
 tb/tb_if_prefetch.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_prefetch.sv
// if_prefetch: instruction-fetch front end ahead of the IF/ID registers.
// Issues one request at a time to a variable-latency instruction memory and
// buffers the returned words in a small circular queue of {pc, instr} pairs.
// Flushes on a MEM-stage redirect, holds on stall, stops issuing on halt.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   imem_req, imem_addr   fetch request and word address (held until ack)
//   imem_ack, imem_data   memory completion and returned instruction word
//   redirect, *_addr      taken branch/jump and its target address
//   hlt                   halt seen at WB; blocks new requests only
//   stall                 downstream not accepting this cycle
//   instr_valid/instr/pc  queue head: instruction and its fetch address + 1
module if_prefetch #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [15:0]   imem_data,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_addr,
  input  logic          hlt,
  input  logic          stall,
  output logic          instr_valid,
  output logic [15:0]   instr,
  output logic [AW-1:0] pc
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_CNT = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {StIdle, StWait, StDiscard} state_e;

  state_e        r_state;
  logic [AW-1:0] r_fetch_addr;
  logic [AW-1:0] r_req_addr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [PW:0]   r_count;
  logic [15:0]   r_data_mem [DEPTH];
  logic [AW-1:0] r_pc_mem   [DEPTH];

  logic          w_pop;
  logic          w_issue;
  logic          w_push;
  logic [PW:0]   w_count_after_pop;
  logic [AW-1:0] w_push_pc;

  assign instr_valid       = (r_count != '0);
  assign w_pop             = instr_valid && !stall && !redirect;
  assign w_count_after_pop = r_count - {{PW{1'b0}}, w_pop};

  // Using the post-pop occupancy lets issue restart in the same cycle a pop
  // frees a slot. rst_n keeps the request low while reset is held.
  assign w_issue = rst_n && (r_state == StIdle) && !hlt && !redirect &&
                   (w_count_after_pop < DEPTH_CNT);

  // In WAIT the fetch address has not moved since issue, so fetch_addr + 1 is
  // the pc of the word being returned in both IDLE and WAIT.
  assign w_push = imem_ack && !redirect &&
                  (((r_state == StIdle) && w_issue) || (r_state == StWait));

  assign w_push_pc = r_fetch_addr + 1'b1;

  // Once issued, the address comes from r_req_addr: a redirect in WAIT moves
  // fetch_addr but the outstanding request must stay stable until its ack.
  assign imem_req  = w_issue || (r_state != StIdle);
  always_comb begin
    imem_addr = '0;
    if (imem_req) begin
      imem_addr = (r_state == StIdle) ? r_fetch_addr : r_req_addr;
    end
  end

  assign instr = instr_valid ? r_data_mem[r_rd_ptr] : 16'h0000;
  assign pc    = instr_valid ? r_pc_mem[r_rd_ptr]   : '0;

  // Fetch FSM and fetch address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_fetch_addr <= '0;
      r_req_addr   <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_issue) begin
            r_req_addr <= r_fetch_addr;
            if (imem_ack) begin
              r_fetch_addr <= w_push_pc;
            end else begin
              r_state <= StWait;
            end
          end
        end
        StWait: begin
          if (imem_ack) begin
            r_state <= StIdle;
            if (!redirect) begin
              r_fetch_addr <= w_push_pc;
            end
          end else if (redirect) begin
            r_state <= StDiscard;
          end
        end
        StDiscard: begin
          // Returned word belongs to the abandoned path; drop it.
          if (imem_ack) begin
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
      // Redirect overrides any increment above.
      if (redirect) begin
        r_fetch_addr <= redirect_addr;
      end
    end
  end

  // Queue pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (redirect) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      r_count <= w_count_after_pop + {{PW{1'b0}}, w_push};
    end
  end

  // Queue storage; reads are masked by instr_valid so no reset is needed.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_data_mem[r_wr_ptr] <= imem_data;
      r_pc_mem[r_wr_ptr]   <= w_push_pc;
    end
  end

endmodule

// File: tb/tb_if_prefetch.sv
// Scoreboard bench for if_prefetch. Stimulus pushes the fetch addresses whose
// entries must be delivered; a monitor pops one per consumed queue head and
// checks pc = addr + 1 and instr = addr ^ 16'hA5A5. A memory model answers
// requests with a programmable number of wait cycles.
module tb_if_prefetch;

  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack = 1'b0;
  logic [15:0]   imem_data = 16'h0;
  logic          redirect = 1'b0;
  logic [AW-1:0] redirect_addr = '0;
  logic          hlt = 1'b0;
  logic          stall = 1'b0;
  logic          instr_valid;
  logic [15:0]   instr;
  logic [AW-1:0] pc;

  int n_tests = 0;
  int n_fail  = 0;
  int n_deliv = 0;

  int            mem_lat = 0;
  bit            man_on  = 1'b0;
  bit            man_ack = 1'b0;
  int            wait_cnt = 0;
  logic [AW-1:0] req_addr = '0;

  logic [AW-1:0] exp_q[$];

  always #5 clk = ~clk;

  if_prefetch #(.DEPTH(4), .AW(AW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_data    (imem_data),
    .redirect     (redirect),
    .redirect_addr(redirect_addr),
    .hlt          (hlt),
    .stall        (stall),
    .instr_valid  (instr_valid),
    .instr        (instr),
    .pc           (pc)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    n_tests++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, got, req, $time);
    end
  endtask

  // Memory model: acts 1 time unit after each falling edge, after stimulus.
  always @(negedge clk) begin
    #1;
    if (man_on) begin
      imem_ack  = man_ack;
      imem_data = 16'hDEAD;
      wait_cnt  = 0;
    end else if (imem_req) begin
      if (wait_cnt == 0) req_addr = imem_addr;
      else chk("addr_stable", 32'(imem_addr), 32'(req_addr));
      if (wait_cnt == mem_lat) begin
        imem_ack  = 1'b1;
        imem_data = imem_addr ^ 16'hA5A5;
        wait_cnt  = 0;
      end else begin
        imem_ack  = 1'b0;
        imem_data = 16'h0;
        wait_cnt++;
      end
    end else begin
      imem_ack = 1'b0;
      wait_cnt = 0;
    end
  end

  // Monitor: one scoreboard pop per consumed head.
  logic [AW-1:0] m_addr;
  logic [AW-1:0] m_pc;
  logic [15:0]   m_instr;
  always @(negedge clk) begin
    #2;
    if (rst_n && instr_valid && !stall && !redirect) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL extra_entry: got pc=%h instr=%h, required no entry (t=%0t)",
                 pc, instr, $time);
      end else begin
        m_addr  = exp_q.pop_front();
        m_pc    = m_addr + 16'd1;
        m_instr = m_addr ^ 16'hA5A5;
        chk("entry_pc", 32'(pc), 32'(m_pc));
        chk("entry_instr", 32'(instr), 32'(m_instr));
        n_deliv++;
      end
    end
  end

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_req"}, 32'(imem_req), 32'd0);
    chk({tag, "_addr"}, 32'(imem_addr), 32'd0);
    chk({tag, "_valid"}, 32'(instr_valid), 32'd0);
    chk({tag, "_instr"}, 32'(instr), 32'd0);
    chk({tag, "_pc"}, 32'(pc), 32'd0);
  endtask

  initial begin
    // 1. Reset and linear fetch, zero-wait memory.
    #1 rst_n = 1'b0;
    #1;
    chk_zero_outputs("reset");
    for (int i = 0; i < 40; i++) exp_q.push_back(AW'(i));
    @(negedge clk); rst_n = 1'b1;
    #3;
    chk("t1_req_first", 32'(imem_req), 32'd1);
    chk("t1_addr_first", 32'(imem_addr), 32'd0);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk); #3;
      chk("t1_valid_cont", 32'(instr_valid), 32'd1);
      chk("t1_addr_seq", 32'(imem_addr), 32'(i));
    end

    // 2. Stall fill and backpressure.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); stall = 1'b1;
      #3;
      if (i >= 3) chk("t2_req_full", 32'(imem_req), 32'd0);
      chk("t2_valid_held", 32'(instr_valid), 32'd1);
    end
    @(negedge clk); stall = 1'b0;
    #3;
    chk("t2_req_resume", 32'(imem_req), 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #3;
      chk("t2_valid_cont", 32'(instr_valid), 32'd1);
    end
    chk("t2_delivered", 32'(n_deliv), 32'd19);

    // 3. Redirect while a latency-3 request for addr 5 is outstanding.
    @(negedge clk);
    rst_n = 1'b0; hlt = 1'b1; stall = 1'b0; mem_lat = 3;
    exp_q.delete(); n_deliv = 0;
    @(negedge clk); rst_n = 1'b1;
    #3 chk("t3_hlt_noreq", 32'(imem_req), 32'd0);
    @(negedge clk); redirect = 1'b1; redirect_addr = 16'h0005;
    @(negedge clk); redirect = 1'b0; hlt = 1'b0;
    #3;
    chk("t3_issue5_req", 32'(imem_req), 32'd1);
    chk("t3_issue5_addr", 32'(imem_addr), 32'h5);
    @(negedge clk); redirect = 1'b1; redirect_addr = 16'h0040;
    for (int i = 0; i < 3; i++) exp_q.push_back(AW'(16'h40 + i));
    @(negedge clk); redirect = 1'b0;
    #3;
    chk("t3_hold5", 32'(imem_addr), 32'h5);
    @(negedge clk); #3;
    chk("t3_ack5", 32'(imem_ack), 32'd1);
    chk("t3_ack5_addr", 32'(imem_addr), 32'h5);
    @(negedge clk); #3;
    chk("t3_next_req", 32'(imem_req), 32'd1);
    chk("t3_next_addr", 32'(imem_addr), 32'h40);
    chk("t3_no_push5", 32'(instr_valid), 32'd0);
    repeat (12) @(negedge clk);
    #3;
    chk("t3_delivered", 32'(n_deliv), 32'd3);

    // 4. Redirect coincident with ack and a possible pop, two entries queued.
    @(negedge clk);
    rst_n = 1'b0; hlt = 1'b0; stall = 1'b1; mem_lat = 1;
    exp_q.delete(); n_deliv = 0;
    @(negedge clk); rst_n = 1'b1;
    repeat (5) @(negedge clk);
    stall = 1'b0; redirect = 1'b1; redirect_addr = 16'h0100;
    for (int i = 0; i < 3; i++) exp_q.push_back(AW'(16'h100 + i));
    #3;
    chk("t4_ack_coincident", 32'(imem_ack), 32'd1);
    chk("t4_head_valid", 32'(instr_valid), 32'd1);
    chk("t4_head_pc", 32'(pc), 32'h1);
    @(negedge clk); redirect = 1'b0;
    #3;
    chk("t4_flushed", 32'(instr_valid), 32'd0);
    chk("t4_req_new", 32'(imem_req), 32'd1);
    chk("t4_addr_new", 32'(imem_addr), 32'h100);
    @(negedge clk); #3;
    chk("t4_still_empty", 32'(instr_valid), 32'd0);
    repeat (5) @(negedge clk);
    #3;
    chk("t4_delivered", 32'(n_deliv), 32'd3);

    // 5. Halt while a latency-2 request for addr 7 is outstanding.
    @(negedge clk);
    rst_n = 1'b0; hlt = 1'b1; stall = 1'b0; mem_lat = 2;
    exp_q.delete(); n_deliv = 0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); redirect = 1'b1; redirect_addr = 16'h0007;
    @(negedge clk); redirect = 1'b0; hlt = 1'b0;
    #3;
    chk("t5_issue7", 32'(imem_addr), 32'h7);
    @(negedge clk); hlt = 1'b1; exp_q.push_back(16'h0007);
    #3 chk("t5_outstanding", 32'(imem_req), 32'd1);
    @(negedge clk); #3;
    chk("t5_ack7", 32'(imem_ack), 32'd1);
    @(negedge clk); #3;
    chk("t5_pushed", 32'(instr_valid), 32'd1);
    chk("t5_no_req", 32'(imem_req), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #3;
      chk("t5_halt_no_req", 32'(imem_req), 32'd0);
      chk("t5_drained", 32'(instr_valid), 32'd0);
    end
    chk("t5_empty_instr", 32'(instr), 32'd0);
    chk("t5_empty_pc", 32'(pc), 32'd0);
    chk("t5_delivered", 32'(n_deliv), 32'd1);

    // 6. Address wrap and one-cycle redirect bubble.
    @(negedge clk);
    hlt = 1'b0; mem_lat = 0; redirect = 1'b1; redirect_addr = 16'hFFFE;
    n_deliv = 0;
    exp_q.push_back(16'hFFFE); exp_q.push_back(16'hFFFF);
    exp_q.push_back(16'h0000); exp_q.push_back(16'h0001);
    #3 chk("t6_redirect_noreq", 32'(imem_req), 32'd0);
    @(negedge clk); redirect = 1'b0;
    #3;
    chk("t6_bubble", 32'(instr_valid), 32'd0);
    chk("t6_addr_fffe", 32'(imem_addr), 32'hFFFE);
    @(negedge clk); #3;
    chk("t6_valid_after_bubble", 32'(instr_valid), 32'd1);
    chk("t6_pc_ffff", 32'(pc), 32'hFFFF);
    chk("t6_addr_ffff", 32'(imem_addr), 32'hFFFF);
    @(negedge clk); #3;
    chk("t6_pc_0000", 32'(pc), 32'h0000);
    chk("t6_addr_0000", 32'(imem_addr), 32'h0000);
    @(negedge clk); #3;
    chk("t6_addr_0001", 32'(imem_addr), 32'h0001);
    chk("t6_delivered", 32'(n_deliv), 32'd3);

    // 7. Reset asserted mid-request; late ack must be ignored.
    @(negedge clk); mem_lat = 3;
    @(negedge clk); #3;
    chk("t7_in_wait", 32'(imem_req), 32'd1);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk_zero_outputs("t7_async");
    man_on = 1'b1; man_ack = 1'b1; hlt = 1'b1;
    @(negedge clk); #3;
    chk("t7_ack_in_reset", 32'(instr_valid), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    #3;
    chk("t7_post_valid", 32'(instr_valid), 32'd0);
    chk("t7_post_req", 32'(imem_req), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #3;
      chk("t7_late_ack_ignored", 32'(instr_valid), 32'd0);
    end
    man_on = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
